// File: rtl/alu_multicycle.sv
// alu_multicycle: registered WIDTH-bit ALU with a start/done handshake and
// iterative multiply/divide into HI/LO (MULT/MULTU/DIV/DIVU/MFHI/MFLO).
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. Operands and opcode are captured at that edge. done pulses for
// exactly one cycle when ALUResult/Zero (and HI/LO for iterative ops) have
// been written. A start while busy=1 is dropped. A new request may be
// accepted on the edge where done is high.
//
// Optional feature macro: ALU_DIV_EN. When it is defined, the restoring
// divider is built and DIV/DIVU run iteratively. When it is undefined,
// opcodes 1010/1011 behave like undefined opcodes.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t               state;
    logic [SHW-1:0]       cnt;
    // Shared datapath register: {partial product} for multiply,
    // {remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   acc_fix;
    logic [WIDTH-1:0]     mcand;
    logic                 neg_lo;
    logic [WIDTH:0]       sum;
    logic                 is_iter;
    logic                 op_sgn;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     sc_result;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;
`ifdef ALU_DIV_EN
    logic                 is_div;
    logic                 div0;
    logic                 neg_hi;
    logic [WIDTH-1:0]     a_orig;
    logic [WIDTH:0]       diff;
`endif

    assign state_dbg = state;
    assign op_sgn    = ALUOperation[0];
    assign mag_a     = (op_sgn && A[WIDTH-1]) ? -A : A;
    assign mag_b     = (op_sgn && B[WIDTH-1]) ? -B : B;

`ifdef ALU_DIV_EN
    assign is_iter = (ALUOperation[3:2] == 2'b10);
`else
    assign is_iter = (ALUOperation[3:1] == 3'b100);
`endif

    // Single-cycle result for the currently presented opcode.
    always_comb begin
        sc_result = '0;
        case (ALUOperation)
            4'b0000: sc_result = A & B;
            4'b0001: sc_result = A | B;
            4'b0010: sc_result = ~(A | B);
            4'b0011: sc_result = A + B;
            4'b0100: sc_result = A - B;
            4'b0101: sc_result = A << shamt;
            4'b0110: sc_result = A >> shamt;
            4'b0111: sc_result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1100: sc_result = HI;
            4'b1101: sc_result = LO;
            default: sc_result = '0;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
`ifdef ALU_DIV_EN
        diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand};
        if (is_div) begin
            acc_next = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Sign fix-up and special cases applied to the last step's value.
    always_comb begin
        acc_fix = neg_lo ? -acc_next : acc_next;
        fin_hi  = acc_fix[2*WIDTH-1:WIDTH];
        fin_lo  = acc_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (is_div) begin
            if (div0) begin
                fin_hi = a_orig;
                fin_lo = '1;
            end else begin
                fin_lo = neg_lo ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
                fin_hi = neg_hi ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    // Control FSM with registered outputs; IDLE and DONE both accept requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            neg_lo    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            HI        <= '0;
            LO        <= '0;
`ifdef ALU_DIV_EN
            is_div    <= 1'b0;
            div0      <= 1'b0;
            neg_hi    <= 1'b0;
            a_orig    <= '0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + SHW'(1);
                    if (cnt == {SHW{1'b1}}) begin
                        HI        <= fin_hi;
                        LO        <= fin_lo;
                        ALUResult <= fin_lo;
                        Zero      <= (fin_lo == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        if (is_iter) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            neg_lo <= op_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                            mcand  <= mag_a;
                            acc    <= {{WIDTH{1'b0}}, mag_b};
`ifdef ALU_DIV_EN
                            is_div <= ALUOperation[1];
                            div0   <= (B == '0);
                            neg_hi <= op_sgn && A[WIDTH-1];
                            a_orig <= A;
                            if (ALUOperation[1]) begin
                                mcand <= mag_b;
                                acc   <= {{WIDTH{1'b0}}, mag_a};
                            end
`endif
                        end else begin
                            ALUResult <= sc_result;
                            Zero      <= (sc_result == '0);
                            done      <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
